retire_trace_capture_ctrl: RTL
==============================

// Module: retire_trace_capture_ctrl
// PURPOSE
//  Captures per-instruction retire records from the core trace port (valid/pc/inst/wrdst/wrdata/wrenx/excpt).
//  Sequences capture with an arm/trigger/stop state machine and buffers records in a DEPTH-entry FIFO.
//  Drains the FIFO to a single valid/ready trace sink (checker or trace writer) in the testbench, counting dropped records.
// PARAMETERS
//  XLEN   32  width of pc, inst, wrdata, cfg_pc_lo/hi
//  DEPTH  16  FIFO entries; power of two, >=2
//  CNT_W  16  width of drop_cnt (saturating)
// PORTS
//  clock              in   1         sole clock; all state updates on rising edge
//  reset              in   1         asynchronous, active-low; asserted (0) clears all state
//  cfg_en             in   1         level: 1 = arm/continue capture, 0 = stop capture
//  cfg_clear          in   1         pulse: flush FIFO, zero drop_cnt, force IDLE
//  cfg_stop_on_excpt  in   1         1 = end capture after a retired excepting record
//  cfg_pc_lo          in   XLEN      trigger window low bound (inclusive)
//  cfg_pc_hi          in   XLEN      trigger window high bound (inclusive)
//  in_valid           in   1         retire record valid this cycle (no backpressure to core)
//  in_pc/in_inst      in   XLEN      retired pc / instruction
//  in_wrdst           in   5         integer destination register
//  in_wrdata          in   XLEN      writeback data
//  in_wrenx           in   1         integer register write enable
//  in_excpt           in   1         record retired with exception
//  out_valid          out  1         FIFO head valid
//  out_ready          in   1         sink accepts head
//  out_pc/out_inst    out  XLEN      head record fields
//  out_wrdst          out  5         head record field
//  out_wrdata         out  XLEN      head record field
//  out_wrenx/out_excpt out 1         head record fields
//  state              out  2         0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
//  count              out  $clog2(DEPTH)+1  FIFO occupancy 0..DEPTH
//  drop_cnt           out  CNT_W     records lost to FIFO full; saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, count=0, drop_cnt=0, out_valid=0, all out_* data=0.
//  push_req: ARMED and in_valid and cfg_pc_lo<=in_pc<=cfg_pc_hi (unsigned), or CAPTURE and in_valid.
//  FSM (evaluated each edge; cfg_clear overrides all below):
//   IDLE:    cfg_en=1 -> ARMED. No pushes.
//   ARMED:   trigger hit -> push the triggering record, go CAPTURE; cfg_en=0 -> IDLE.
//   CAPTURE: push every in_valid record; cfg_en=0 -> DRAIN (the record of that cycle is still pushed);
//            in_valid&in_excpt&cfg_stop_on_excpt -> push the record, go DRAIN.
//   DRAIN:   no pushes; when count==0 (incl. pop emptying it this cycle) -> IDLE.
//  cfg_clear=1: next state IDLE, FIFO pointers/count=0, drop_cnt=0; no push/pop/drop counted that cycle.
//  FIFO: pop = out_valid & out_ready. Push accepted if count<DEPTH or pop in same cycle.
//   Full and no pop: record dropped, drop_cnt+=1 unless all-ones. FIFO contents unchanged.
//   Simultaneous push+pop: count unchanged, head advances, new record at tail.
//   Pointers wrap modulo DEPTH; count distinguishes full from empty.
//  Latency: record pushed at edge N is visible at out_* with out_valid=1 after edge N (when FIFO was empty).
//  out_* stable while out_valid=1 and out_ready=0; out_* undefined-free: read from head entry, 0 when empty.
//  Sink stalls never backpressure the core; loss is only via drop_cnt.
//  Async reset mid-capture: all state cleared immediately; no partial record survives.
// TESTING
//  Window 0x80000100..0x80000100, en=1, records pc 0x80000000,0x80000100,0x80000104 -> state 1->2, FIFO holds 2 (0x100,0x104).
//  CAPTURE, stop_on_excpt=1, excpt record pc 0x80000200 -> pushed, state=3; ready=1 drains -> state 0 once count=0.
//  DEPTH=16, out_ready=0, 20 valid records in CAPTURE -> count=16, drop_cnt=4, head pc = first captured.
//  Full FIFO, out_ready=1 and in_valid same cycle for 5 cycles -> count stays 16, drop_cnt unchanged, order preserved.
//  cfg_clear pulse with count=9, drop_cnt=3 -> next cycle state=0, count=0, drop_cnt=0, out_valid=0.
//  reset asserted (0) mid-CAPTURE with count=5 -> immediately out_valid=0, count=0, state=0; deassert, re-arm works.

Source files
------------

// File: rtl/retire_trace_capture_ctrl.sv
// retire_trace_capture_ctrl
//   Captures per-instruction retire records from the core trace port.
//   An arm/trigger/stop FSM decides which records are kept. Kept records go
//   into a DEPTH-entry FIFO that drains to one valid/ready trace sink.
//   The core is never backpressured. Records that arrive while the FIFO is
//   full are dropped and counted in a saturating counter.
// Ports
//   clock, reset          : clock; asynchronous active-low reset
//   cfg_*                 : enable level, clear pulse, stop-on-exception, pc trigger window
//   in_*                  : retire record from the core (valid has no ready)
//   out_*                 : FIFO head record and its valid/ready handshake
//   state                 : 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
//   count                 : FIFO occupancy, 0..DEPTH
//   drop_cnt              : number of records lost to a full FIFO; saturates at all-ones
module retire_trace_capture_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_en,
    input  logic                     cfg_clear,
    input  logic                     cfg_stop_on_excpt,
    input  logic [XLEN-1:0]          cfg_pc_lo,
    input  logic [XLEN-1:0]          cfg_pc_hi,
    input  logic                     in_valid,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    input  logic [4:0]               in_wrdst,
    input  logic [XLEN-1:0]          in_wrdata,
    input  logic                     in_wrenx,
    input  logic                     in_excpt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [4:0]               out_wrdst,
    output logic [XLEN-1:0]          out_wrdata,
    output logic                     out_wrenx,
    output logic                     out_excpt,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CountW = PtrW + 1;
    localparam int unsigned RecW   = 3 * XLEN + 5 + 2;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDrain   = 2'd3
    } state_e;

    state_e            state_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CountW-1:0] count_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [RecW-1:0]   rec_mem [DEPTH];
    logic [RecW-1:0]   head_rec;

    logic in_window;
    logic trig_hit;
    logic full;
    logic push_req;
    logic push;
    logic pop;
    logic drop;
    logic stop_excpt;

    always_comb begin
        in_window  = (in_pc >= cfg_pc_lo) && (in_pc <= cfg_pc_hi);
        trig_hit   = in_valid && in_window;
        full       = (count_q == CountW'(DEPTH));
        // A clear cycle performs no push, pop or drop.
        push_req   = !cfg_clear && in_valid &&
                     ((state_q == StArmed && in_window) || state_q == StCapture);
        pop        = !cfg_clear && out_valid && out_ready;
        // A pop in the same cycle frees the slot that the push uses.
        push       = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        stop_excpt = in_valid && in_excpt && cfg_stop_on_excpt;
    end

    // Control: FSM, FIFO pointers/occupancy and drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else if (cfg_clear) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CountW'(1);
            else if (!push && pop) count_q <= count_q - CountW'(1);
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);

            unique case (state_q)
                StIdle: begin
                    if (cfg_en) state_q <= StArmed;
                end
                StArmed: begin
                    if (trig_hit)     state_q <= StCapture;
                    else if (!cfg_en) state_q <= StIdle;
                end
                StCapture: begin
                    if (!cfg_en || stop_excpt) state_q <= StDrain;
                end
                StDrain: begin
                    // No pushes here, so the FIFO empties when the last entry pops.
                    if (count_q == '0 || (count_q == CountW'(1) && pop)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Record storage carries no reset; only entries below count are ever visible.
    always_ff @(posedge clock) begin
        if (push) begin
            rec_mem[wr_ptr_q] <= {in_pc, in_inst, in_wrdst, in_wrdata, in_wrenx, in_excpt};
        end
    end

    always_comb begin
        out_valid = (count_q != '0);
        head_rec  = out_valid ? rec_mem[rd_ptr_q] : '0;
        {out_pc, out_inst, out_wrdst, out_wrdata, out_wrenx, out_excpt} = head_rec;
    end

    assign state    = state_q;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;

endmodule
